// File: rtl/exec_seq.sv
// Multi-cycle operand sequencer: reads two RAM operands, drives an ALU of configurable
// latency and writes the result back. Define EXEC_SEQ_FLAGS_EN for the zero flag and compare opcode.
module exec_seq #(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int OPW = 4,
    parameter int ALU_LAT = 1,
    parameter logic [OPW-1:0] LDI_OP = 4'b0111,
    parameter logic [OPW-1:0] CMP_OP = 4'b1111
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic [AW-1:0]  op1,
    input  logic [DW-1:0]  op2,
    input  logic [DW-1:0]  memdat,
    input  logic [DW-1:0]  aluout,
    output logic [DW-1:0]  aluop1,
    output logic [DW-1:0]  aluop2,
    output logic [OPW-1:0] aluopcode,
    output logic [AW-1:0]  address,
    output logic [DW-1:0]  datout,
    output logic           rw,
    output logic           cs,
    output logic           busy,
    output logic           done,
    output logic           zflag
);

    typedef enum logic [2:0] {
        S_IDLE, S_RDA, S_RDB, S_CAPB, S_EXEC, S_WB, S_LDI, S_DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t         r_state, w_stateNext;
    logic [OPW-1:0] r_opcode, w_opcode;
    logic [AW-1:0]  r_op1, w_op1;
    logic [AW-1:0]  r_opB, w_opB;
    logic [3:0]     r_cnt, w_cnt;
    logic [DW-1:0]  r_aluop1, w_aluop1;
    logic [DW-1:0]  r_aluop2, w_aluop2;
    logic [OPW-1:0] r_aluopcode, w_aluopcode;
    logic [AW-1:0]  r_address, w_address;
    logic [DW-1:0]  r_datout, w_datout;
    logic           r_rw, w_rw;
    logic           r_cs, w_cs;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic           r_zflag, w_zflag;

    // Every output is computed one cycle ahead so it is valid for the whole state it belongs to.
    always_comb begin
        w_stateNext = r_state;
        w_opcode    = r_opcode;
        w_op1       = r_op1;
        w_opB       = r_opB;
        w_cnt       = r_cnt;
        w_aluop1    = r_aluop1;
        w_aluop2    = r_aluop2;
        w_aluopcode = r_aluopcode;
        w_address   = r_address;
        w_datout    = r_datout;
        w_rw        = r_rw;
        w_cs        = r_cs;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_zflag     = r_zflag;

        case (r_state)
            S_IDLE: begin
                w_cs   = 1'b0;
                w_rw   = 1'b1;
                w_busy = 1'b0;
                if (start) begin
                    w_opcode  = opcode;
                    w_op1     = op1;
                    w_opB     = op2[AW-1:0];
                    w_busy    = 1'b1;
                    w_address = op1;
                    w_cs      = 1'b1;
                    if (opcode == LDI_OP) begin
                        w_datout    = op2;
                        w_rw        = 1'b0;
                        w_stateNext = S_LDI;
                    end else begin
                        w_rw        = 1'b1;
                        w_stateNext = S_RDA;
                    end
                end
            end
            S_RDA: begin
                w_address   = r_opB;
                w_cs        = 1'b1;
                w_rw        = 1'b1;
                w_stateNext = S_RDB;
            end
            S_RDB: begin
                w_aluop1    = memdat;
                w_cs        = 1'b0;
                w_stateNext = S_CAPB;
            end
            S_CAPB: begin
                w_aluop2    = memdat;
                w_aluopcode = r_opcode;
                w_cnt       = LAT_M1;
                w_stateNext = S_EXEC;
            end
            S_EXEC: begin
                if (r_cnt == 4'd0) begin
`ifdef EXEC_SEQ_FLAGS_EN
                    w_zflag = (aluout == '0);
                    if (r_opcode == CMP_OP) begin
                        w_done      = 1'b1;
                        w_stateNext = S_DONE;
                    end else begin
                        w_datout    = aluout;
                        w_address   = r_op1;
                        w_cs        = 1'b1;
                        w_rw        = 1'b0;
                        w_stateNext = S_WB;
                    end
`else
                    w_datout    = aluout;
                    w_address   = r_op1;
                    w_cs        = 1'b1;
                    w_rw        = 1'b0;
                    w_stateNext = S_WB;
`endif
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_WB, S_LDI: begin
                w_cs        = 1'b0;
                w_rw        = 1'b1;
                w_done      = 1'b1;
                w_stateNext = S_DONE;
            end
            S_DONE: begin
                w_cs        = 1'b0;
                w_rw        = 1'b1;
                w_busy      = 1'b0;
                w_stateNext = S_IDLE;
            end
            default: begin
                w_cs        = 1'b0;
                w_rw        = 1'b1;
                w_busy      = 1'b0;
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Asynchronous reset releases the RAM at once so an aborted write never lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_op1       <= '0;
            r_opB       <= '0;
            r_cnt       <= '0;
            r_aluop1    <= '0;
            r_aluop2    <= '0;
            r_aluopcode <= '0;
            r_address   <= '0;
            r_datout    <= '0;
            r_rw        <= 1'b1;
            r_cs        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_zflag     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_opcode    <= w_opcode;
            r_op1       <= w_op1;
            r_opB       <= w_opB;
            r_cnt       <= w_cnt;
            r_aluop1    <= w_aluop1;
            r_aluop2    <= w_aluop2;
            r_aluopcode <= w_aluopcode;
            r_address   <= w_address;
            r_datout    <= w_datout;
            r_rw        <= w_rw;
            r_cs        <= w_cs;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_zflag     <= w_zflag;
        end
    end

    assign aluop1    = r_aluop1;
    assign aluop2    = r_aluop2;
    assign aluopcode = r_aluopcode;
    assign address   = r_address;
    assign datout    = r_datout;
    assign rw        = r_rw;
    assign cs        = r_cs;
    assign busy      = r_busy;
    assign done      = r_done;
    assign zflag     = r_zflag;

endmodule

// File: tb/tb_exec_seq.sv
// Directed bench for exec_seq: two instances (ALU latency 1 and 3) share the instruction
// inputs, each with its own synchronous RAM and ALU model.
module tb_exec_seq;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int OPW = 4;
`ifdef EXEC_SEQ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [OPW-1:0] opcode = '0;
    logic [AW-1:0]  op1 = '0;
    logic [DW-1:0]  op2 = '0;

    logic [DW-1:0]  memdat1, aluout1, aluop1_1, aluop2_1, datout1;
    logic [OPW-1:0] aluopcode1;
    logic [AW-1:0]  address1;
    logic           rw1, cs1, busy1, done1, zflag1;

    logic [DW-1:0]  memdat3, aluout3, aluop1_3, aluop2_3, datout3;
    logic [OPW-1:0] aluopcode3;
    logic [AW-1:0]  address3;
    logic           rw3, cs3, busy3, done3, zflag3;

    logic [DW-1:0]  mem1 [16];
    logic [DW-1:0]  mem3 [16];
    logic [DW-1:0]  pipe3 [2];

    logic           t1Cs [0:31], t1Rw [0:31], t1Done [0:31], t1Busy [0:31];
    logic [AW-1:0]  t1Addr [0:31];
    logic [DW-1:0]  t1Dat [0:31];
    logic           t3Cs [0:31], t3Rw [0:31], t3Done [0:31];
    logic [DW-1:0]  t3Dat [0:31];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_seq #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op1(op1), .op2(op2),
        .memdat(memdat1), .aluout(aluout1), .aluop1(aluop1_1), .aluop2(aluop2_1),
        .aluopcode(aluopcode1), .address(address1), .datout(datout1), .rw(rw1),
        .cs(cs1), .busy(busy1), .done(done1), .zflag(zflag1)
    );

    exec_seq #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op1(op1), .op2(op2),
        .memdat(memdat3), .aluout(aluout3), .aluop1(aluop1_3), .aluop2(aluop2_3),
        .aluopcode(aluopcode3), .address(address3), .datout(datout3), .rw(rw3),
        .cs(cs3), .busy(busy3), .done(done3), .zflag(zflag3)
    );

    function automatic logic [DW-1:0] aluF(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        case (op)
            4'd1:       return a + b;
            4'd2, 4'hF: return a - b;
            default:    return a ^ b;
        endcase
    endfunction

    // Synchronous RAMs: read data appears the cycle after the address cycle.
    always @(posedge clk) begin
        if (cs1 && !rw1) mem1[address1] <= datout1;
        if (cs1 && rw1)  memdat1 <= mem1[address1];
        if (cs3 && !rw3) mem3[address3] <= datout3;
        if (cs3 && rw3)  memdat3 <= mem3[address3];
    end

    // Latency-3 ALU: result valid three edges after its operands change, stale before that.
    always @(posedge clk) begin
        pipe3[0] <= aluF(aluopcode3, aluop1_3, aluop2_3);
        pipe3[1] <= pipe3[0];
    end

    assign aluout1 = aluF(aluopcode1, aluop1_1, aluop2_1);
    assign aluout3 = pipe3[1];

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [OPW-1:0] op, input logic [AW-1:0] a,
                                 input logic [DW-1:0] b);
        opcode = op;
        op1    = a;
        op2    = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem1[a] <= v;
        mem3[a] <= v;
    endtask

    // Records cycles 1..n of the instruction just issued.
    task automatic traceRun(input int n);
        for (int c = 1; c <= n; c++) begin
            t1Cs[c] = cs1;  t1Rw[c] = rw1;  t1Done[c] = done1; t1Busy[c] = busy1;
            t1Addr[c] = address1; t1Dat[c] = datout1;
            t3Cs[c] = cs3;  t3Rw[c] = rw3;  t3Done[c] = done3; t3Dat[c] = datout3;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int writes1(input int n);
        int w = 0;
        for (int c = 1; c <= n; c++) if (t1Cs[c] && !t1Rw[c]) w++;
        return w;
    endfunction

    function automatic int writes3(input int n);
        int w = 0;
        for (int c = 1; c <= n; c++) if (t3Cs[c] && !t3Rw[c]) w++;
        return w;
    endfunction

    task automatic waitIdle();
        int n = 0;
        while ((busy1 || busy3) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_wait", {31'd0, busy1 | busy3}, 32'd0);
    endtask

    initial begin
        int dn1, dn3, cntDone1, cntDone3, cntWr1, cntAcc;

        for (int i = 0; i < 16; i++) begin
            mem1[i] <= '0;
            mem3[i] <= '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs", {31'd0, cs1}, 32'd0);
        checkOutput("rst_rw", {31'd0, rw1}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy1}, 32'd0);
        checkOutput("rst_done", {31'd0, done1}, 32'd0);
        checkOutput("rst_addr", {28'd0, address1}, 32'd0);
        checkOutput("rst_datout", {16'd0, datout1}, 32'd0);
        checkOutput("rst_zflag", {31'd0, zflag1}, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_cs", {31'd0, cs1 | cs3}, 32'd0);

        // Load immediate
        applyStimulus(4'd7, 4'd3, 16'hBEEF);
        traceRun(3);
        checkOutput("ldi_cs1", {31'd0, t1Cs[1]}, 32'd1);
        checkOutput("ldi_rw1", {31'd0, t1Rw[1]}, 32'd0);
        checkOutput("ldi_addr1", {28'd0, t1Addr[1]}, 32'd3);
        checkOutput("ldi_dat1", {16'd0, t1Dat[1]}, 32'hBEEF);
        checkOutput("ldi_busy1", {31'd0, t1Busy[1]}, 32'd1);
        checkOutput("ldi_done1", {31'd0, t1Done[1]}, 32'd0);
        checkOutput("ldi_done2", {31'd0, t1Done[2]}, 32'd1);
        checkOutput("ldi_cs2", {31'd0, t1Cs[2]}, 32'd0);
        checkOutput("ldi_busy3", {31'd0, t1Busy[3]}, 32'd0);
        checkOutput("ldi_writes", writes1(3), 32'd1);
        checkOutput("ldi_mem1", {16'd0, mem1[3]}, 32'hBEEF);
        checkOutput("ldi_mem3", {16'd0, mem3[3]}, 32'hBEEF);
        checkOutput("ldi_aluopc", {28'd0, aluopcode1}, 32'd0);

        // ADD, latency 1 and 3
        preload(4'd2, 16'd5);
        preload(4'd9, 16'd7);
        applyStimulus(4'd1, 4'd2, 16'd9);
        traceRun(10);
        checkOutput("add_rda_addr", {28'd0, t1Addr[1]}, 32'd2);
        checkOutput("add_rda_cs", {31'd0, t1Cs[1]}, 32'd1);
        checkOutput("add_rdb_addr", {28'd0, t1Addr[2]}, 32'd9);
        checkOutput("add_rdb_rw", {31'd0, t1Rw[2]}, 32'd1);
        checkOutput("add_capb_cs", {31'd0, t1Cs[3]}, 32'd0);
        checkOutput("add_wb_rw", {31'd0, t1Rw[5]}, 32'd0);
        checkOutput("add_wb_addr", {28'd0, t1Addr[5]}, 32'd2);
        checkOutput("add_wb_dat", {16'd0, t1Dat[5]}, 32'd12);
        checkOutput("add_done5", {31'd0, t1Done[5]}, 32'd0);
        checkOutput("add_done6", {31'd0, t1Done[6]}, 32'd1);
        checkOutput("add_busy6", {31'd0, t1Busy[6]}, 32'd1);
        checkOutput("add_busy7", {31'd0, t1Busy[7]}, 32'd0);
        checkOutput("add_writes", writes1(10), 32'd1);
        checkOutput("add_aluop1", {16'd0, aluop1_1}, 32'd5);
        checkOutput("add_aluop2", {16'd0, aluop2_1}, 32'd7);
        checkOutput("add_aluopc", {28'd0, aluopcode1}, 32'd1);
        checkOutput("add_mem", {16'd0, mem1[2]}, 32'd12);
        checkOutput("add_zflag", {31'd0, zflag1}, 32'd0);
        checkOutput("lat3_cs6", {31'd0, t3Cs[6]}, 32'd0);
        checkOutput("lat3_wb_rw", {31'd0, t3Rw[7]}, 32'd0);
        checkOutput("lat3_wb_dat", {16'd0, t3Dat[7]}, 32'd12);
        checkOutput("lat3_done7", {31'd0, t3Done[7]}, 32'd0);
        checkOutput("lat3_done8", {31'd0, t3Done[8]}, 32'd1);
        checkOutput("lat3_writes", writes3(10), 32'd1);
        checkOutput("lat3_mem", {16'd0, mem3[2]}, 32'd12);

        // start held high: latency-1 instance completes exactly two instructions in 13 cycles
        cntDone1 = 0; cntDone3 = 0; cntWr1 = 0;
        opcode = 4'd1; op1 = 4'd2; op2 = 16'd9; start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk);
            #1;
            if (done1) cntDone1++;
            if (done3) cntDone3++;
            if (cs1 && !rw1) cntWr1++;
        end
        start = 1'b0;
        checkOutput("hs_done1", cntDone1, 32'd2);
        checkOutput("hs_writes1", cntWr1, 32'd2);
        checkOutput("hs_done3", cntDone3, 32'd1);
        waitIdle();
        checkOutput("hs_mem1", {16'd0, mem1[2]}, 32'd26);
        checkOutput("hs_mem3", {16'd0, mem3[2]}, 32'd26);

        // Compare opcode
        preload(4'd1, 16'd8);
        preload(4'd4, 16'd8);
        applyStimulus(4'hF, 4'd1, 16'd4);
        traceRun(9);
        dn1 = FLAGS ? 5 : 6;
        dn3 = FLAGS ? 7 : 8;
        checkOutput("cmp_done1", {31'd0, t1Done[dn1]}, 32'd1);
        checkOutput("cmp_early1", {31'd0, t1Done[dn1-1]}, 32'd0);
        checkOutput("cmp_done3", {31'd0, t3Done[dn3]}, 32'd1);
        checkOutput("cmp_writes1", writes1(9), FLAGS ? 32'd0 : 32'd1);
        checkOutput("cmp_writes3", writes3(9), FLAGS ? 32'd0 : 32'd1);
        checkOutput("cmp_mem", {16'd0, mem1[1]}, FLAGS ? 32'd8 : 32'd0);
        checkOutput("cmp_zflag1", {31'd0, zflag1}, {31'd0, FLAGS});
        checkOutput("cmp_zflag3", {31'd0, zflag3}, {31'd0, FLAGS});
        waitIdle();
        applyStimulus(4'd7, 4'd5, 16'h1234);
        traceRun(3);
        checkOutput("ldi_keep_zflag", {31'd0, zflag1}, {31'd0, FLAGS});
        checkOutput("ldi_keep_aluopc", {28'd0, aluopcode1}, 32'hF);
        checkOutput("ldi2_mem", {16'd0, mem1[5]}, 32'h1234);

        // Reset in the middle of RDB
        applyStimulus(4'd1, 4'd2, 16'd9);
        @(posedge clk);
        #2;
        checkOutput("pre_rst_cs", {31'd0, cs1}, 32'd1);
        checkOutput("pre_rst_addr", {28'd0, address1}, 32'd9);
        rst = 1'b0;
        #1;
        checkOutput("abort_cs", {31'd0, cs1}, 32'd0);
        checkOutput("abort_rw", {31'd0, rw1}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy1}, 32'd0);
        checkOutput("abort_addr", {28'd0, address1}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cntAcc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (cs1 || cs3 || busy1) cntAcc++;
        end
        checkOutput("post_rst_idle", cntAcc, 32'd0);
        checkOutput("post_rst_mem", {16'd0, mem1[2]}, 32'd26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_seq.md
# exec_seq

Parametrised multi-cycle operand sequencer between instruction decode, a single-port synchronous RAM and a combinational/pipelined ALU. On a `start` pulse it latches one instruction, reads two operands from RAM, presents them to the ALU, waits a configurable ALU latency, and writes the result back to the first operand's address. A load-immediate opcode instead writes `op2` directly to RAM. It supersedes the fixed 16-bit/4-bit sequencer and adds:

- a start/busy/done handshake;
- configurable ALU latency;
- an optional compare/flag mode.

## Interface
- `DW`, 16: data width of RAM words, ALU operands/result, and `op2`.
- `AW`, 4: RAM address width; `op1` width, and the B source address is `op2[AW-1:0]`.
- `OPW`, 4: opcode width.
- `ALU_LAT`, 1: cycles the ALU needs after operands/opcode are stable; legal range 1..15.
- `LDI_OP`, 4'b0111: load-immediate opcode value.
- `CMP_OP`, 4'b1111: compare opcode value, used only under `EXEC_SEQ_FLAGS_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `start` in 1: instruction request, sampled only in IDLE.
- `opcode` in OPW: operation, latched on accepted start.
- `op1` in AW: source-A and destination address, latched.
- `op2` in DW: B address in `[AW-1:0]`, or immediate for LDI; latched.
- `memdat` in DW: RAM read data, valid one cycle after the address cycle.
- `aluout` in DW: ALU result.
- `aluop1`, `aluop2` out DW: ALU operands.
- `aluopcode` out OPW: ALU opcode.
- `address` out AW: RAM address.
- `datout` out DW: RAM write data.
- `rw` out 1: 1 = read, 0 = write.
- `cs` out 1: RAM chip select.
- `busy` out 1: instruction in flight.
- `done` out 1: one-cycle completion pulse.
- `zflag` out 1: result-zero flag.

## Operation
- All outputs are registered. Memory controls take their value on the edge entering a state and hold it for that state.
- Reset values: `aluop1`, `aluop2`, `datout`, `address`, `aluopcode` = 0; `rw` = 1; `cs`, `done`, `busy`, `zflag` = 0; state = IDLE.
- Reset asserted mid-instruction aborts immediately. `cs` drops and `rw` = 1 asynchronously, so there is no partial write. The instruction is lost.

States:
- **IDLE**: `cs` = 0, `rw` = 1, `busy` = 0.
  - On `start` = 1, latch `opcode`/`op1`/`op2` and set `busy` = 1.
  - Go to LDI if opcode == `LDI_OP`, else RDA.
- **RDA**: `address` = `op1`, `cs` = 1, `rw` = 1. Go to RDB.
- **RDB**: `address` = `op2[AW-1:0]`, `cs` = 1, `rw` = 1. Sample `memdat` into `aluop1` at end of cycle. Go to CAPB.
- **CAPB**: `cs` = 0. Sample `memdat` into `aluop2` at end of cycle. Set `aluopcode` = latched opcode and load the latency counter with `ALU_LAT`-1. Go to EXEC.
- **EXEC**: count down. At count 0, go to WB with `datout` <= `aluout`, `address` = `op1`, `cs` = 1, `rw` = 0.
- **WB**: single write cycle. Go to DONE.
- **LDI**: `address` = `op1`, `datout` = `op2`, `cs` = 1, `rw` = 0 for one cycle. `aluopcode` unchanged. Go to DONE.
- **DONE**: `cs` = 0, `rw` = 1, `done` = 1 for this cycle only. `busy` falls on exit. Go to IDLE.

Other rules:
- `start` outside IDLE is ignored, including the DONE cycle.
- Back-to-back instructions need `start` high in the IDLE cycle after DONE.
- `aluop1`/`aluop2`/`aluopcode` hold their last values until the next instruction updates them.
- `op1` == `op2[AW-1:0]` is legal: both reads return the same word.

## Timing
- Start accepted at edge E0.
- ALU instruction:
  - RDA is cycle 1 and RDB cycle 2.
  - CAPB is cycle 3, then EXEC for cycles 4..3+`ALU_LAT`.
  - WB is cycle 4+`ALU_LAT`; `done` is high in cycle 5+`ALU_LAT` (6 for `ALU_LAT` = 1).
- LDI: LDI in cycle 1, `done` in cycle 2.
- `aluout` is sampled exactly `ALU_LAT` cycles after `aluop2`/`aluopcode` update.
- `busy` is high from cycle 1 through the DONE cycle inclusive.

## Configuration
- `EXEC_SEQ_FLAGS_EN` defined:
  - On the EXEC→WB decision, `zflag` <= (`aluout` == 0).
  - `zflag` holds until the next ALU instruction; LDI does not affect it.
  - Opcode `CMP_OP` goes EXEC→DONE directly, with no write (`cs` stays 0). `done` appears one cycle earlier than for other ALU ops.
- Undefined:
  - `zflag` is tied to 0.
  - `CMP_OP` is an ordinary ALU opcode with writeback.

## Test plan
- **Reset**: hold `rst` = 0 mid-RDB → `cs` = 0, `rw` = 1, `busy` = 0, `address` = 0 immediately. After release, IDLE with no RAM access.
- **LDI**: `opcode` = 7, `op1` = 3, `op2` = 16'hBEEF → one write cycle, `address` = 3, `datout` = BEEF, `rw` = 0, `cs` = 1. `done` in cycle 2; RAM[3] = BEEF.
- **ADD**: RAM[2] = 5, RAM[9] = 7, `opcode` = 1, `op1` = 2, `op2` = 9, ALU adds, `ALU_LAT` = 1 → `aluop1` = 5, `aluop2` = 7, write of 12 to address 2. `done` in cycle 6.
- **ALU latency**: `ALU_LAT` = 3, same ADD → WB in cycle 7, `done` in cycle 8. `datout` = 12, not an intermediate value.
- **Handshake**: `start` held high through the whole instruction → exactly two instructions for 2×(5+`ALU_LAT`) + 1 cycles. No access while `busy`.
- **Flags** (`EXEC_SEQ_FLAGS_EN`): RAM[1] = RAM[4] = 8, `CMP_OP` with ALU subtract → no write, `zflag` = 1, `done` in cycle 5. A following LDI leaves `zflag` = 1.
